// File: rtl/dram_channel_client.sv
// Per-channel DRAM burst initiator: issues a command word on the write stream, then either
// forwards write data from a source stream or collects read data into a show-ahead FIFO.
//   state | meaning
//   IDLE  | waiting for a burst request (req_ready high)
//   CMD   | presenting the command word (tuser=1) until accepted
//   WDATA | passing source words through to the write stream
//   RDATA | collecting read responses into the FIFO
module dram_channel_client #(
  parameter int RD_FIFO_DEPTH    = 32,
  parameter int AF_MARGIN        = 12,
  parameter int SMALLPILE_THRESH = 4
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [26:0]  req_addr,
  input  logic [26:0]  req_length,
  input  logic         req_wen,
  input  logic [127:0] src_data,
  input  logic         src_valid,
  output logic         src_ready,
  output logic [127:0] sink_data,
  output logic         sink_valid,
  input  logic         sink_ready,
  output logic [127:0] write_axis_data,
  output logic         write_axis_tuser,
  output logic         write_axis_valid,
  output logic         write_axis_smallpile,
  input  logic         write_axis_ready,
  input  logic [127:0] read_axis_data,
  input  logic         read_axis_tuser,
  input  logic         read_axis_valid,
  output logic         read_axis_af,
  output logic         read_axis_ready,
  output logic         busy,
  output logic         done,
  output logic         overflow_err,
  output logic         stray_err
);

  localparam int AW = $clog2(RD_FIFO_DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(RD_FIFO_DEPTH);
  localparam logic [AW:0]   CNT_AF   = (AW+1)'(RD_FIFO_DEPTH - AF_MARGIN);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [26:0]   SP_LVL   = 27'(SMALLPILE_THRESH);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WDATA, S_RDATA} state_t;

  state_t        state_q, state_d;
  logic [26:0]   addr_q, addr_d, len_q, len_d, rem_q, rem_d;
  logic          wen_q, wen_d, done_q, done_d;
  logic          rd_take;

  logic [127:0]  mem_q [RD_FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          af_q, ovf_q, stray_q;
  logic          fifo_full, push, pop;

  logic unused_tuser;
  assign unused_tuser = read_axis_tuser;

  always_comb begin
    state_d              = state_q;
    addr_d               = addr_q;
    len_d                = len_q;
    wen_d                = wen_q;
    rem_d                = rem_q;
    done_d               = 1'b0;
    rd_take              = 1'b0;
    req_ready            = (state_q == S_IDLE) && !done_q;
    src_ready            = 1'b0;
    write_axis_valid     = 1'b0;
    write_axis_tuser     = 1'b0;
    write_axis_data      = '0;
    write_axis_smallpile = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          addr_d = req_addr;
          len_d  = req_length;
          wen_d  = req_wen;
          rem_d  = req_length;
          if (req_length == '0) done_d = 1'b1;
          else                  state_d = S_CMD;
        end
      end
      S_CMD: begin
        write_axis_valid = 1'b1;
        write_axis_tuser = 1'b1;
        write_axis_data  = {73'd0, addr_q, len_q, wen_q};
        if (write_axis_ready) state_d = wen_q ? S_WDATA : S_RDATA;
      end
      S_WDATA: begin
        write_axis_valid     = src_valid;
        write_axis_data      = src_data;
        src_ready            = write_axis_ready;
        write_axis_smallpile = (rem_q <= SP_LVL);
        if (src_valid && write_axis_ready && rem_q != '0) begin
          rem_d = rem_q - 27'd1;
          if (rem_q == 27'd1) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_RDATA: begin
        rd_take = read_axis_valid;
        if (read_axis_valid && rem_q != '0) begin
          rem_d = rem_q - 27'd1;
          if (rem_q == 27'd1) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign fifo_full  = (cnt_q == CNT_FULL);
  assign sink_valid = (cnt_q != '0);
  assign sink_data  = mem_q[rptr_q];
  assign pop        = sink_valid && sink_ready;
  assign push       = rd_take && (!fifo_full || pop);

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CNT_ONE;
    else if (!push && pop) cnt_d = cnt_q - CNT_ONE;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      wen_q   <= 1'b0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
      stray_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      wen_q   <= wen_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      af_q    <= (cnt_d >= CNT_AF);
      if (push) wptr_q <= wptr_q + PTR_ONE;
      if (pop)  rptr_q <= rptr_q + PTR_ONE;
      if (rd_take && fifo_full && !pop)               ovf_q   <= 1'b1;
      if (read_axis_valid && state_q != S_RDATA)      stray_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) mem_q[wptr_q] <= read_axis_data;
  end

  assign read_axis_af    = af_q;
  assign read_axis_ready = 1'b1;
  assign busy            = (state_q != S_IDLE);
  assign done            = done_q;
  assign overflow_err    = ovf_q;
  assign stray_err       = stray_q;

endmodule
